random_range_sampler: RTL and testbench
=======================================

RANDOM_RANGE_SAMPLER -- requirements
Module: random_range_sampler

Interface
REQ-001 SHALL have parameter Width, default 32: width of the raw random word and of limit/out_data.
REQ-002 SHALL have parameter Depth, default 4: output FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port random_in, input, Width: raw word from the CA random generator; combinational from its registered state.
REQ-006 SHALL have port rng_ce, output, 1: clock-enable to the generator; high means the current random_in is consumed at this edge.
REQ-007 SHALL have port limit, input, Width: exclusive upper bound of the sample range.
REQ-008 SHALL have port limit_load, input, 1: single-cycle strobe that captures limit.
REQ-009 SHALL have port out_data, output, Width: sample in [0, limit); valid only while out_valid is high.
REQ-010 SHALL have port out_valid, output, 1: FIFO non-empty.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts; a pop occurs when out_valid && out_ready.
REQ-012 SHALL have port limit_err, output, 1: high while the captured limit is 0.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, RUN.
REQ-014 IDLE: rng_ce=0, no pushes; limit_load with limit!=0 -> SETUP; limit_load with limit==0 -> IDLE and limit_err=1.
REQ-015 SETUP: one cycle; registers mask = smallest 2^k-1 >= limit-1 (mask=0 for limit=1, all-ones for limit > 2^(Width-1)); -> RUN.
REQ-016 RUN: rng_ce = 1 whenever the FIFO is not full or a pop occurs this cycle; rng_ce = 0 otherwise.
REQ-017 When rng_ce=1, candidate = random_in & mask; if candidate < limit_reg it SHALL be pushed at that edge, otherwise it is discarded (rejected).
REQ-018 Each random_in value SHALL be consumed at most once; no candidate is drawn while rng_ce=0.
REQ-019 Latency: an accepted candidate SHALL appear with out_valid=1 in the cycle after the push edge when the FIFO was empty.
REQ-020 FIFO order SHALL be first-in first-out; a simultaneous push and pop on a full FIFO SHALL be allowed and keep the count unchanged.
REQ-021 limit_load in any state SHALL flush the FIFO (out_valid=0 next cycle), drop any in-flight candidate, and re-enter SETUP (or IDLE if limit==0).
REQ-022 limit_load with limit!=0 SHALL clear limit_err.
REQ-023 The occupancy counter SHALL be Width-independent, log2(Depth)+1 bits, with no wrap beyond Depth.

Reset
REQ-024 While rst is high: state=IDLE, FIFO empty, out_valid=0, rng_ce=0, limit_err=0, limit_reg=0, mask=0, out_data=0.
REQ-025 Asserting rst mid-RUN SHALL discard all buffered samples; after release, no samples are produced until limit_load.

Configuration
REQ-026 Macro RANDOM_RANGE_SAMPLER_STATS_EN: when defined, adds output reject_count, 16 bits, counting rejected candidates; it saturates at 16'hFFFF, is cleared by rst and limit_load, and holds in IDLE.
REQ-027 Without RANDOM_RANGE_SAMPLER_STATS_EN, the reject_count port and its counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-028 limit=10, random_in sequence 3,12,15,9 (rng_ce=1, out_ready=1) -> mask=15; outputs 3,9; rejects 2; reject_count=2 with STATS_EN.
REQ-029 limit=1 -> mask=0; every draw yields 0; out_valid continuous after the first push; reject_count stays 0.
REQ-030 limit=5, out_ready=0 for 20 cycles -> FIFO fills to 4; rng_ce=0 while full; accepting one pop re-asserts rng_ce in the same cycle.
REQ-031 FIFO holding 3 samples, limit_load with limit=100 -> out_valid=0 next cycle; mask=127 after SETUP; stale samples are never output.
REQ-032 limit_load with limit=0 -> IDLE, limit_err=1, rng_ce=0; then limit=7 -> limit_err=0, mask=7, sampling resumes.
REQ-033 rst asserted asynchronously mid-RUN with a full FIFO -> out_valid, rng_ce, and limit_err all drop immediately; all-zero state after release.

Source files
------------

// File: rtl/random_range_sampler.sv
// rtl/random_range_sampler.sv - uniform sampler over [0, limit) by mask-and-reject on a raw random word
//
// Purpose:
//   Draws raw words from an external random generator. Each word is masked
//   down to the smallest power-of-two range that covers the limit. Words that
//   still land at or above the limit are rejected. Accepted samples go into a
//   small FIFO, and the consumer drains it with a valid/ready handshake.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   random_in    raw random word (combinational from the generator state)
//   rng_ce       generator clock-enable; high = random_in consumed this edge
//   limit        exclusive upper bound of the sample range
//   limit_load   one-cycle strobe that captures limit, flushes the FIFO
//   out_data     head-of-FIFO sample (0 while out_valid is low)
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts the head sample
//   limit_err    high while the captured limit is 0
//   reject_count saturating count of rejected candidates (only with
//                RANDOM_RANGE_SAMPLER_STATS_EN defined)
//
// Optional feature macro: RANDOM_RANGE_SAMPLER_STATS_EN

module random_range_sampler #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] random_in,
  output logic             rng_ce,
  input  logic [Width-1:0] limit,
  input  logic             limit_load,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             limit_err
`ifdef RANDOM_RANGE_SAMPLER_STATS_EN
  ,
  output logic [15:0]      reject_count
`endif
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [Width-1:0] limit_q;
  logic [Width-1:0] mask_q;
  logic             limit_err_q;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;

  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             reject;
  logic [Width-1:0] candidate;
  logic             cand_in_range;

  // Smallest 2^k-1 covering lim-1: smear the highest set bit of lim-1 down
  // through all lower positions. Gives 0 for lim=1 and all-ones once
  // lim-1 has its top bit set.
  function automatic logic [Width-1:0] range_mask(input logic [Width-1:0] lim);
    logic [Width-1:0] m;
    m = lim - Width'(1);
    for (int s = 1; s < Width; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

  // ------------------------------------------------------------------
  // Handshake and candidate qualification
  // ------------------------------------------------------------------
  assign fifo_full     = (count_q == CntW'(Depth));
  assign out_valid     = (count_q != '0);
  assign pop           = out_valid && out_ready;
  assign candidate     = random_in & mask_q;
  assign cand_in_range = (candidate < limit_q);
  assign push          = rng_ce && cand_in_range;
  assign reject        = rng_ce && !cand_in_range;

  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign limit_err = limit_err_q;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state and generator enable
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rng_ce  = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_SETUP: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        // A pop frees a slot at this edge, so a full FIFO can still draw.
        rng_ce = !fifo_full || pop;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A new limit overrides everything. Any word presented this cycle was
    // drawn under the old range, so it is left unconsumed.
    if (limit_load) begin
      rng_ce  = 1'b0;
      state_d = (limit == '0) ? S_IDLE : S_SETUP;
    end
  end

  // ------------------------------------------------------------------
  // Limit / mask / error registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      limit_q     <= '0;
      mask_q      <= '0;
      limit_err_q <= 1'b0;
    end else if (limit_load) begin
      limit_q     <= limit;
      limit_err_q <= (limit == '0);
    end else if (state_q == S_SETUP) begin
      mask_q <= range_mask(limit_q);
    end
  end

  // ------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (limit_load) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  // Storage is not reset. Entries are only visible through out_data while
  // the occupancy count says they are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= candidate;
    end
  end

`ifdef RANDOM_RANGE_SAMPLER_STATS_EN
  // ------------------------------------------------------------------
  // Rejection statistics
  // ------------------------------------------------------------------
  logic [15:0] reject_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject_count_q <= '0;
    end else if (limit_load) begin
      reject_count_q <= '0;
    end else if (reject && (reject_count_q != 16'hFFFF)) begin
      reject_count_q <= reject_count_q + 16'd1;
    end
  end

  assign reject_count = reject_count_q;
`endif

endmodule

// File: tb/tb_random_range_sampler.sv
// tb/tb_random_range_sampler.sv - self-checking bench for random_range_sampler

module tb_random_range_sampler;

  localparam int W = 8;
  localparam int D = 4;
  localparam int M_IDLE = 0, M_SETUP = 1, M_RUN = 2;

  logic         clk;
  logic         rst;
  logic [W-1:0] random_in;
  logic         rng_ce;
  logic [W-1:0] limit;
  logic         limit_load;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         limit_err;
`ifdef RANDOM_RANGE_SAMPLER_STATS_EN
  logic [15:0]  reject_count;
`endif

  random_range_sampler #(.Width(W), .Depth(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .random_in   (random_in),
    .rng_ce      (rng_ce),
    .limit       (limit),
    .limit_load  (limit_load),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .limit_err   (limit_err)
`ifdef RANDOM_RANGE_SAMPLER_STATS_EN
    ,
    .reject_count(reject_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int m_state;
  int m_limit;
  int m_mask;
  bit m_err;
  int m_rej;
  int q[$];

  // Last sampled DUT outputs, for the table checks.
  bit a_valid, a_ce, a_err;
  int a_data;

  typedef struct {
    int lim;
    bit ll;
    int rin;
    bit rdy;
    bit e_valid;
    int e_data;
    bit e_ce;
    bit e_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Smallest all-ones value that is >= lim-1, found by counting up.
  function automatic int calc_mask(input int lim);
    int m;
    m = 0;
    while (m < lim - 1) m = (m << 1) | 1;
    return m;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_limit = 0;
    m_mask  = 0;
    m_err   = 0;
    m_rej   = 0;
    q.delete();
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then let
  // the edge happen and advance the model.
  task automatic step(input int lim, input bit ll, input int rin, input bit rdy);
    bit e_valid, e_ce, pop;
    int e_data, cand, rw, lw;
    rw = rin & ((1 << W) - 1);
    lw = lim & ((1 << W) - 1);
    @(negedge clk);
    limit      = lw[W-1:0];
    limit_load = ll;
    random_in  = rw[W-1:0];
    out_ready  = rdy;
    #1;
    e_valid = (q.size() != 0);
    e_data  = e_valid ? q[0] : 0;
    pop     = e_valid && rdy;
    e_ce    = (m_state == M_RUN) && !ll && ((q.size() < D) || pop);
    a_valid = out_valid;
    a_ce    = rng_ce;
    a_err   = limit_err;
    a_data  = int'(out_data);
    chk("out_valid", out_valid, e_valid);
    chk("rng_ce", rng_ce, e_ce);
    chk("limit_err", limit_err, m_err);
    if (e_valid) chk("out_data", out_data, e_data);
`ifdef RANDOM_RANGE_SAMPLER_STATS_EN
    chk("reject_count", reject_count, m_rej);
`endif
    @(posedge clk);
    if (ll) begin
      q.delete();
      m_limit = lw;
      m_rej   = 0;
      if (lw == 0) begin
        m_state = M_IDLE;
        m_err   = 1;
      end else begin
        m_state = M_SETUP;
        m_err   = 0;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (m_state == M_SETUP) begin
        m_mask  = calc_mask(m_limit);
        m_state = M_RUN;
      end else if (e_ce) begin
        cand = rw & m_mask;
        if (cand < m_limit) q.push_back(cand);
        else if (m_rej < 65535) m_rej++;
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    random_in  = '0;
    limit      = '0;
    limit_load = 1'b0;
    out_ready  = 1'b0;
    model_reset();

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rng_ce", rng_ce, 0);
    chk("rst_limit_err", limit_err, 0);
    chk("rst_out_data", out_data, 0);
`ifdef RANDOM_RANGE_SAMPLER_STATS_EN
    chk("rst_reject_count", reject_count, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // limit=10, draws 3,12,15,9 -> outputs 3 and 9
    tbl[0] = '{10, 1, 0,  1, 0, 0, 0, 0};
    tbl[1] = '{10, 0, 0,  1, 0, 0, 0, 0};
    tbl[2] = '{10, 0, 3,  1, 0, 0, 1, 0};
    tbl[3] = '{10, 0, 12, 1, 1, 3, 1, 0};
    tbl[4] = '{10, 0, 15, 1, 0, 0, 1, 0};
    tbl[5] = '{10, 0, 9,  1, 0, 0, 1, 0};
    tbl[6] = '{10, 0, 15, 1, 1, 9, 1, 0};
    tbl[7] = '{10, 0, 15, 1, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].lim, tbl[i].ll, tbl[i].rin, tbl[i].rdy);
      chk("tbl_valid", a_valid, tbl[i].e_valid);
      chk("tbl_ce", a_ce, tbl[i].e_ce);
      chk("tbl_err", a_err, tbl[i].e_err);
      if (tbl[i].e_valid) chk("tbl_data", a_data, tbl[i].e_data);
    end

    // limit=1: every draw yields 0, output continuous
    step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, $urandom, 1);
      if (i >= 1) begin
        chk("lim1_valid", a_valid, 1);
        chk("lim1_data", a_data, 0);
      end
    end

    // limit=5, stalled consumer: fill, hold, then one pop re-enables draws
    step(5, 1, 0, 0);
    step(5, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(5, 0, i % 5, 0);
    step(5, 0, 1, 0);
    chk("full_ce_low", a_ce, 0);
    chk("full_valid", a_valid, 1);
    step(5, 0, 2, 1);
    chk("pop_ce_high", a_ce, 1);

    // three buffered samples flushed by a new limit of 100
    step(5, 1, 0, 0);
    step(5, 0, 0, 0);
    step(5, 0, 1, 0);
    step(5, 0, 2, 0);
    step(5, 0, 3, 0);
    step(100, 1, 4, 0);
    chk("flush_prev_valid", a_valid, 1);
    step(100, 0, 4, 1);
    chk("flush_valid", a_valid, 0);
    step(100, 0, 8'hE3, 1);
    chk("flush_run_valid", a_valid, 0);
    step(100, 0, 8'h64, 1);
    chk("mask127_data", a_data, 99);

    // zero limit -> error, then recover with limit=7
    step(0, 1, 0, 1);
    step(0, 0, 5, 1);
    chk("zero_err", a_err, 1);
    chk("zero_ce", a_ce, 0);
    step(7, 1, 0, 1);
    step(7, 0, 0, 1);
    chk("recover_err", a_err, 0);
    step(7, 0, 8'hFE, 1);
    step(7, 0, 8'hFF, 1);
    chk("mask7_data", a_data, 6);

    // randomized traffic, including large limits and occasional reloads
    for (int i = 0; i < 500; i++) begin
      int lim;
      bit ll;
      ll = ($urandom_range(0, 39) == 0) || (i == 0);
      case ($urandom_range(0, 4))
        0:       lim = 0;
        1:       lim = 1;
        2:       lim = $urandom_range(129, 255);
        default: lim = $urandom_range(2, 128);
      endcase
      step(lim, ll, $urandom, $urandom_range(0, 3) != 0);
    end

    // asynchronous reset mid-run with a full FIFO
    step(5, 1, 0, 0);
    step(5, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(5, 0, i % 5, 0);
    chk("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ce", rng_ce, 0);
    chk("arst_err", limit_err, 0);
    chk("arst_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(5, 0, i, 1);
      chk("post_rst_valid", a_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
